// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants and capture-state enum for the FFT front end
package fft_pkg;

    localparam int DATA_W   = 12;
    localparam int N_LOG2   = 11;
    localparam int MIDSCALE = 2048;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        CAPTURE = 2'd2,
        PLAY    = 2'd3
    } cap_state_e;

endpackage

// File: rtl/frame_ram.sv
// rtl/frame_ram.sv - simple dual-port frame RAM, synchronous write, 1-cycle registered read
module frame_ram
    import fft_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int AW = N_LOG2
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [0:(1<<AW)-1];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Only the read register is reset so replayed data reads 0 out of reset.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/adc_frame_capture.sv
// rtl/adc_frame_capture.sv - decimate ADC stream, capture one frame, replay as gap-free burst
// Optional rising-edge trigger in ARM when TRIG_EN is defined.
module adc_frame_capture #(
    parameter int DATA_W     = fft_pkg::DATA_W,
    parameter int N_LOG2     = fft_pkg::N_LOG2,
`ifdef TRIG_EN
    parameter int TRIG_LEVEL = fft_pkg::MIDSCALE,
`endif
    parameter int DECIM_W    = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [DATA_W-1:0]  i_adc_data,
    input  logic               i_adc_strobe,
    input  logic [DECIM_W-1:0] i_decim,
    input  logic               i_start,
    input  logic               i_continuous,
    output logic [DATA_W-1:0]  o_frame_data,
    output logic [N_LOG2-1:0]  o_frame_addr,
    output logic               o_frame_valid,
    output logic               o_frame_last,
    output logic               o_busy,
    output logic               o_overrun
);
    import fft_pkg::*;

    localparam logic [N_LOG2-1:0] LAST_ADDR = '1;

    cap_state_e          r_state, w_next;
    logic                r_start_d;
    logic [DECIM_W-1:0]  r_decim;
    logic                r_cont;
    logic [DECIM_W-1:0]  r_dcnt;
    logic [N_LOG2-1:0]   r_wr_cnt;
    logic [N_LOG2-1:0]   r_rd_cnt;
    logic                r_overrun;
    logic                r_valid;
    logic [N_LOG2-1:0]   r_addr;
    logic                r_last;

    logic w_start_edge, w_start_act, w_accept, w_trigger, w_arm_entry;
    logic w_we, w_re, w_busy;

    assign w_start_edge = i_start & ~r_start_d;
    assign w_start_act  = w_start_edge && ((r_state == IDLE) || (r_state == ARM));
    assign w_accept     = i_adc_strobe && (r_dcnt == '0) && (r_state != IDLE);

`ifdef TRIG_EN
    localparam logic [DATA_W-1:0] TRIG_THR = DATA_W'(TRIG_LEVEL);
    logic [DATA_W-1:0] r_prev;
    logic              r_force;

    assign w_trigger = r_force || ((r_prev < TRIG_THR) && (i_adc_data >= TRIG_THR));

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_prev  <= '0;
            r_force <= 1'b0;
        end else if (w_arm_entry) begin
            r_prev  <= '0;
            r_force <= 1'b0;
        end else if (r_state == ARM) begin
            if (w_accept)     r_prev  <= i_adc_data;
            if (w_start_edge) r_force <= 1'b1;
        end
    end
`else
    assign w_trigger = 1'b1;
`endif

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start_edge)                      w_next = ARM;
            ARM:     if (w_accept && w_trigger)             w_next = CAPTURE;
            CAPTURE: if (w_accept && r_wr_cnt == LAST_ADDR) w_next = PLAY;
            PLAY:    if (r_rd_cnt == LAST_ADDR)             w_next = r_cont ? ARM : IDLE;
            default:                                        w_next = IDLE;
        endcase
    end

    always_comb begin
        w_busy      = (r_state != IDLE);
        w_re        = (r_state == PLAY);
        w_we        = w_accept && (((r_state == ARM) && w_trigger) || (r_state == CAPTURE));
        w_arm_entry = ((r_state == IDLE) && w_start_edge) ||
                      ((r_state == PLAY) && (r_rd_cnt == LAST_ADDR) && r_cont);
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_start_d <= 1'b0;
            r_decim   <= '0;
            r_cont    <= 1'b0;
            r_dcnt    <= '0;
            r_wr_cnt  <= '0;
            r_rd_cnt  <= '0;
            r_overrun <= 1'b0;
            r_valid   <= 1'b0;
            r_addr    <= '0;
            r_last    <= 1'b0;
        end else begin
            r_start_d <= i_start;
            if (w_start_act) begin
                r_decim <= i_decim;
                r_cont  <= i_continuous;
            end
            // The decimator free-runs outside IDLE, including during PLAY.
            if (w_arm_entry) begin
                r_dcnt <= '0;
            end else if (i_adc_strobe && (r_state != IDLE)) begin
                r_dcnt <= (r_dcnt == '0) ? r_decim : r_dcnt - 1'b1;
            end
            if (w_we) r_wr_cnt <= r_wr_cnt + 1'b1;
            if (w_re) r_rd_cnt <= r_rd_cnt + 1'b1;
            if (w_start_act) begin
                r_overrun <= 1'b0;
            end else if ((r_state == PLAY) && w_accept && r_cont) begin
                r_overrun <= 1'b1;
            end
            r_valid <= w_re;
            r_addr  <= w_re ? r_rd_cnt : '0;
            r_last  <= w_re && (r_rd_cnt == LAST_ADDR);
        end
    end

    frame_ram #(
        .DW (DATA_W),
        .AW (N_LOG2)
    ) u_frame_ram (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_we    (w_we),
        .i_waddr (r_wr_cnt),
        .i_wdata (i_adc_data),
        .i_re    (w_re),
        .i_raddr (r_rd_cnt),
        .o_rdata (o_frame_data)
    );

    assign o_frame_addr  = r_addr;
    assign o_frame_valid = r_valid;
    assign o_frame_last  = r_last;
    assign o_busy        = w_busy;
    assign o_overrun     = r_overrun;

endmodule

// File: tb/tb_adc_frame_capture.sv
// tb/tb_adc_frame_capture.sv - directed self-checking bench for adc_frame_capture
module tb_adc_frame_capture;

    localparam int CLK_P = 10;
    localparam int NPTS  = 2048;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] adc_data = '0;
    logic        adc_strobe = 1'b0;
    logic [7:0]  decim = '0;
    logic        start = 1'b0;
    logic        continuous = 1'b0;
    logic [11:0] frame_data;
    logic [10:0] frame_addr;
    logic        frame_valid;
    logic        frame_last;
    logic        busy;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    logic [11:0] cap_data [NPTS];
    int  n_beats, n_last, last_idx, addr_errs, gap;
    bit  got_frame;
    time first_t, last_t, last_strobe_t;

    int sin_tab [16] = '{1000, 924, 707, 383, 0, -383, -707, -924,
                         -1000, -924, -707, -383, 0, 383, 707, 924};

    always #(CLK_P/2) clk = ~clk;

    adc_frame_capture dut (
        .i_clk        (clk),
        .i_rst        (rst_n),
        .i_adc_data   (adc_data),
        .i_adc_strobe (adc_strobe),
        .i_decim      (decim),
        .i_start      (start),
        .i_continuous (continuous),
        .o_frame_data (frame_data),
        .o_frame_addr (frame_addr),
        .o_frame_valid(frame_valid),
        .o_frame_last (frame_last),
        .o_busy       (busy),
        .o_overrun    (overrun)
    );

    function automatic logic [11:0] sval(input int kind, input int i);
        case (kind)
            0:       return 12'(i);
            1:       return 12'(i >> 1);
            2:       return 12'(4095 - i);
            3:       return 12'(2048 + sin_tab[i % 16]);
            default: return 12'(i + 100);
        endcase
    endfunction

    task automatic apply_reset();
        @(posedge clk); #2;
        rst_n = 1'b0; adc_strobe = 1'b0; start = 1'b0; continuous = 1'b0; decim = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic do_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic drive_stream(input int n, input int period, input int kind, input int start_at);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            adc_data      = sval(kind, i);
            adc_strobe    = 1'b1;
            start         = (i == start_at);
            last_strobe_t = $time;
            for (int p = 1; p < period; p++) begin
                @(posedge clk); #1;
                adc_strobe = 1'b0;
                start      = 1'b0;
            end
        end
        @(posedge clk); #1;
        adc_strobe = 1'b0;
        start      = 1'b0;
    endtask

    task automatic collect(input int budget);
        int  k = 0;
        bit  started = 0;
        bit  done = 0;
        n_beats = 0; n_last = 0; last_idx = -1; addr_errs = 0; gap = 0;
        while (!done && k < budget) begin
            @(negedge clk);
            k++;
            if (frame_valid) begin
                if (!started) begin
                    started = 1;
                    first_t = $time;
                end
                if (n_beats < NPTS) cap_data[n_beats] = frame_data;
                if (frame_addr !== 11'(n_beats)) addr_errs++;
                if (frame_last) begin
                    n_last++;
                    last_idx = n_beats;
                    last_t   = $time;
                    done     = 1;
                end
                n_beats++;
            end else if (started) begin
                gap++;
                done = 1;
            end
        end
        got_frame = done;
    endtask

    task automatic test_reset_state();
        apply_reset();
        @(negedge clk);
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b want 0", frame_valid); end
        checks++; if (frame_last !== 1'b0) begin errors++; $display("FAIL rst_last got %0b want 0", frame_last); end
        checks++; if (frame_addr !== 11'd0) begin errors++; $display("FAIL rst_addr got %0d want 0", frame_addr); end
        checks++; if (frame_data !== 12'd0) begin errors++; $display("FAIL rst_data got %0d want 0", frame_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b want 0", busy); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun got %0b want 0", overrun); end
    endtask

    task automatic test_reset_mid_capture();
        int derr = 0;
        apply_reset();
        do_start();
        drive_stream(500, 1, 4, -1);
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midcap_busy got %0b want 1", busy); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_rst_busy got %0b want 0", busy); end
        checks++; if ({frame_valid, frame_last, frame_addr, frame_data} !== 25'd0) begin
            errors++; $display("FAIL async_rst_outs got %0h want 0", {frame_valid, frame_last, frame_addr, frame_data}); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        collect(40);
        checks++; if (n_beats !== 0) begin errors++; $display("FAIL post_rst_beats got %0d want 0", n_beats); end
        do_start();
        fork
            drive_stream(NPTS, 1, 4, -1);
            collect(5000);
        join
        for (int k = 0; k < NPTS; k++) if (cap_data[k] !== 12'(k + 100)) derr++;
        checks++; if (n_beats !== NPTS) begin errors++; $display("FAIL rearm_beats got %0d want %0d", n_beats, NPTS); end
        checks++; if (cap_data[0] !== 12'd100) begin errors++; $display("FAIL rearm_addr0 got %0d want 100", cap_data[0]); end
        checks++; if (derr !== 0 || addr_errs !== 0) begin
            errors++; $display("FAIL rearm_content got data_errs=%0d addr_errs=%0d want 0", derr, addr_errs); end
    endtask

    task automatic test_single_frame();
        int derr = 0;
        apply_reset();
        decim = 8'd0;
        do_start();
        fork
            drive_stream(NPTS, 4, 0, -1);
            collect(12000);
        join
        for (int k = 0; k < NPTS; k++) if (cap_data[k] !== 12'(k)) derr++;
        checks++; if (!got_frame || n_beats !== NPTS || gap !== 0) begin
            errors++; $display("FAIL ramp_beats got %0d gap=%0d done=%0b want %0d", n_beats, gap, got_frame, NPTS); end
        checks++; if (derr !== 0) begin errors++; $display("FAIL ramp_data got %0d errors want 0", derr); end
        checks++; if (addr_errs !== 0) begin errors++; $display("FAIL ramp_addr got %0d errors want 0", addr_errs); end
        checks++; if (n_last !== 1 || last_idx !== NPTS - 1) begin
            errors++; $display("FAIL ramp_last got count=%0d idx=%0d want 1 at %0d", n_last, last_idx, NPTS - 1); end
        checks++; if (first_t - last_strobe_t !== 64'(2*CLK_P + CLK_P/2 - 1)) begin
            errors++; $display("FAIL ramp_latency got %0t want %0d", first_t - last_strobe_t, 2*CLK_P + CLK_P/2 - 1); end
        checks++; if (last_t - first_t !== 64'((NPTS - 1) * CLK_P)) begin
            errors++; $display("FAIL ramp_burst_len got %0t want %0d", last_t - first_t, (NPTS - 1) * CLK_P); end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || frame_valid !== 1'b0) begin
            errors++; $display("FAIL ramp_after got busy=%0b valid=%0b want 0 0", busy, frame_valid); end
    endtask

    task automatic test_decimation();
        int derr = 0;
        apply_reset();
        decim = 8'd3;
        do_start();
        fork
            drive_stream(4 * NPTS, 1, 0, -1);
            collect(12000);
        join
        for (int k = 0; k < NPTS; k++) if (cap_data[k] !== 12'(4 * k)) derr++;
        checks++; if (n_beats !== NPTS) begin errors++; $display("FAIL decim_beats got %0d want %0d", n_beats, NPTS); end
        checks++; if (cap_data[1] !== 12'd4) begin errors++; $display("FAIL decim_addr1 got %0d want 4", cap_data[1]); end
        checks++; if (derr !== 0) begin errors++; $display("FAIL decim_data got %0d errors want 0", derr); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL decim_overrun got %0b want 0", overrun); end
    endtask

    task automatic test_continuous();
        int derr1 = 0;
        int derr2 = 0;
        int nb1 = 0;
        apply_reset();
        decim = 8'd0;
        continuous = 1'b1;
        do_start();
        continuous = 1'b0;
        fork
            drive_stream(4 * NPTS, 1, 1, -1);
            begin
                collect(4500);
                nb1 = n_beats;
                for (int k = 0; k < NPTS; k++) if (cap_data[k] !== 12'(k >> 1)) derr1++;
                checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL cont_overrun1 got %0b want 1", overrun); end
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL cont_rearm_busy got %0b want 1", busy); end
                collect(4500);
                for (int k = 0; k < NPTS; k++) if (cap_data[k] !== 12'(2048 + (k >> 1))) derr2++;
            end
        join
        checks++; if (nb1 !== NPTS || n_beats !== NPTS) begin
            errors++; $display("FAIL cont_beats got %0d,%0d want %0d", nb1, n_beats, NPTS); end
        checks++; if (derr1 !== 0) begin errors++; $display("FAIL cont_frame1 got %0d errors want 0", derr1); end
        checks++; if (derr2 !== 0) begin errors++; $display("FAIL cont_frame2 got %0d errors want 0", derr2); end
        @(negedge clk);
        checks++; if (busy !== 1'b1 || overrun !== 1'b1) begin
            errors++; $display("FAIL cont_armed got busy=%0b overrun=%0b want 1 1", busy, overrun); end
        do_start();
        @(negedge clk);
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL cont_clear got %0b want 0", overrun); end
    endtask

    task automatic test_start_in_capture();
        int derr = 0;
        apply_reset();
        decim = 8'd0;
        do_start();
        fork
            drive_stream(NPTS, 1, 2, 1000);
            collect(5000);
        join
        for (int k = 0; k < NPTS; k++) if (cap_data[k] !== 12'(4095 - k)) derr++;
        checks++; if (n_beats !== NPTS || n_last !== 1) begin
            errors++; $display("FAIL ign_start_beats got %0d last=%0d want %0d 1", n_beats, n_last, NPTS); end
        checks++; if (derr !== 0) begin errors++; $display("FAIL ign_start_data got %0d errors want 0", derr); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_start_busy got %0b want 0", busy); end
    endtask

    task automatic test_trigger();
        int derr = 0;
        apply_reset();
        decim = 8'd0;
        fork
            drive_stream(2100, 1, 3, 6);
            collect(5000);
        join
        for (int k = 0; k < NPTS; k++) if (cap_data[k] !== 12'(2048 + sin_tab[(12 + k) % 16])) derr++;
        checks++; if (cap_data[0] !== 12'd2048) begin errors++; $display("FAIL trig_addr0 got %0d want 2048", cap_data[0]); end
        checks++; if (cap_data[1] !== 12'd2431) begin errors++; $display("FAIL trig_addr1 got %0d want 2431", cap_data[1]); end
        checks++; if (derr !== 0 || n_beats !== NPTS) begin
            errors++; $display("FAIL trig_frame got errs=%0d beats=%0d want 0 %0d", derr, n_beats, NPTS); end
    endtask

    task automatic test_force_trigger();
        int derr = 0;
        apply_reset();
        decim = 8'd0;
        do_start();
        fork
            drive_stream(2100, 1, 0, 3);
            collect(5000);
        join
        for (int k = 0; k < NPTS; k++) if (cap_data[k] !== 12'(k + 4)) derr++;
        checks++; if (cap_data[0] !== 12'd4) begin errors++; $display("FAIL force_addr0 got %0d want 4", cap_data[0]); end
        checks++; if (derr !== 0 || n_beats !== NPTS) begin
            errors++; $display("FAIL force_frame got errs=%0d beats=%0d want 0 %0d", derr, n_beats, NPTS); end
    endtask

    initial begin
        test_reset_state();
`ifdef TRIG_EN
        test_trigger();
        test_force_trigger();
`else
        test_reset_mid_capture();
        test_single_frame();
        test_decimation();
        test_continuous();
        test_start_in_capture();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
